board_seed_loader: RTL and testbench



---
 rtl/seed_pkg.sv | 29 ++
 rtl/sync_edge.sv | 37 +++
 rtl/board_seed_loader.sv | 163 ++++++++++++++++
 tb/tb_board_seed_loader.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seed_pkg.sv
// Shared definitions for the Game of Life seed loader.
//   CELLS          : cell count of the default 8x8 board
//   state_t        : loader states IDLE / SHIFT / OFFER
//   PRESET_*       : built-in seed patterns, bit k = cell k = row*8 + col
//   LFSR_TAPS/SEED : 64-bit Fibonacci LFSR (taps 64,63,61,60) used when
//                    SEED_LFSR_EN is defined
package seed_pkg;

  localparam int CELLS = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    OFFER = 2'd2
  } state_t;

  localparam logic [63:0] PRESET_UW      = 64'h50A8_8888_0609_0909;
  localparam logic [63:0] PRESET_GLIDER  = 64'h0000_0000_0007_0402;
  localparam logic [63:0] PRESET_BLINKER = 64'h0000_0000_0038_0000;

  // Tap positions 64,63,61,60 map to bits 63,62,60,59.
  localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;
  localparam logic [63:0] LFSR_SEED = 64'h0000_0000_0000_ACE1;

  function automatic logic [63:0] lfsr_next(input logic [63:0] s);
    return {s[62:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchronizer followed by a registered edge detector.
//   clk, reset : system clock, asynchronous active-high reset
//   async_in   : pin input, asynchronous to clk
//   level      : synchronized level, aligned with the rise/fall pulses
//   rise, fall : one-cycle pulses, SYNC_STAGES+1 cycles after the pin edge
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      r_sync[0] <= async_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= r_sync[SYNC_STAGES-1];
      rise   <= r_sync[SYNC_STAGES-1] & ~r_prev;
      fall   <= ~r_sync[SYNC_STAGES-1] & r_prev;
    end
  end

  assign level = r_prev;

endmodule

// File: rtl/board_seed_loader.sv
// Seed feeder for the Game of Life engine. Loads a pattern from a three-wire
// serial link or a preset ROM into a pending buffer, then offers it to the
// engine on the next frame_tick with a valid/ready handshake.
//   clk, reset             : system clock, asynchronous active-high reset
//   ser_clk/ser_data/ser_latch : serial link pins (asynchronous), cell 0 first
//   preset_sel, preset_go  : preset index and asynchronous load button
//   frame_tick             : one-cycle pulse at vsync rise
//   seed_ready/seed_valid/seed_cells : handshake to the engine
//   busy                   : shifting or a pattern is pending
//   xfer_err               : sticky, last serial transfer had a wrong bit count
// Optional feature: define SEED_LFSR_EN to make preset 3 a snapshot of a
// free-running 64-bit LFSR; otherwise preset 3 is an empty board.
module board_seed_loader
  import seed_pkg::*;
#(
  parameter int BIT_WIDTH   = 3,
  parameter int BIT_HEIGHT  = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    ser_clk,
  input  logic                                    ser_data,
  input  logic                                    ser_latch,
  input  logic [1:0]                              preset_sel,
  input  logic                                    preset_go,
  input  logic                                    frame_tick,
  input  logic                                    seed_ready,
  output logic                                    seed_valid,
  output logic [2**(BIT_WIDTH+BIT_HEIGHT)-1:0]    seed_cells,
  output logic                                    busy,
  output logic                                    xfer_err
);

  localparam int          IDX_W    = BIT_WIDTH + BIT_HEIGHT;
  localparam int          N_CELLS  = 2**IDX_W;
  localparam logic [6:0]  CNT_FULL = 7'(N_CELLS);
  localparam logic [6:0]  CNT_SAT  = 7'(N_CELLS + 1);

  logic w_clk_lvl, w_clk_rise, w_clk_fall;
  logic w_dat_lvl, w_dat_rise, w_dat_fall;
  logic w_lat_lvl, w_lat_rise, w_lat_fall;
  logic w_go_lvl,  w_go_rise,  w_go_fall;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(clk), .reset(reset), .async_in(ser_clk),
    .level(w_clk_lvl), .rise(w_clk_rise), .fall(w_clk_fall));
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dat (
    .clk(clk), .reset(reset), .async_in(ser_data),
    .level(w_dat_lvl), .rise(w_dat_rise), .fall(w_dat_fall));
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lat (
    .clk(clk), .reset(reset), .async_in(ser_latch),
    .level(w_lat_lvl), .rise(w_lat_rise), .fall(w_lat_fall));
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_go (
    .clk(clk), .reset(reset), .async_in(preset_go),
    .level(w_go_lvl), .rise(w_go_rise), .fall(w_go_fall));

  logic w_unused;
  assign w_unused = ^{w_clk_lvl, w_clk_fall, w_dat_rise, w_dat_fall,
                      w_lat_lvl, w_go_lvl, w_go_fall};

  state_t             r_state, r_ret;
  logic [6:0]         r_bit_cnt;
  logic [N_CELLS-1:0] r_stage, r_pend, r_offer;
  logic               r_pend_v, r_valid, r_err;

  // The link mode (IDLE/SHIFT) keeps evolving underneath an OFFER; r_ret
  // carries it while the offer is outstanding.
  state_t             w_mode, w_mode_nxt;
  logic               w_shift_mode, w_open, w_close, w_good, w_preset, w_take;
  logic [N_CELLS-1:0] w_rom;

`ifdef SEED_LFSR_EN
  logic [63:0] r_lfsr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_lfsr <= LFSR_SEED;
    else       r_lfsr <= lfsr_next(r_lfsr);
  end
`endif

  always_comb begin
    case (preset_sel)
      2'd0:    w_rom = N_CELLS'(PRESET_UW);
      2'd1:    w_rom = N_CELLS'(PRESET_GLIDER);
      2'd2:    w_rom = N_CELLS'(PRESET_BLINKER);
`ifdef SEED_LFSR_EN
      default: w_rom = N_CELLS'(r_lfsr);
`else
      default: w_rom = '0;
`endif
    endcase
  end

  always_comb begin
    w_mode       = (r_state == OFFER) ? r_ret : r_state;
    w_shift_mode = (w_mode == SHIFT);
    w_open       = !w_shift_mode && w_lat_rise;
    w_close      = w_shift_mode && w_lat_fall;
    w_good       = w_close && (r_bit_cnt == CNT_FULL);
    w_preset     = !w_shift_mode && !w_open && w_go_rise;
    w_take       = frame_tick && r_pend_v && (r_state != OFFER);
    w_mode_nxt   = w_mode;
    if (w_open)       w_mode_nxt = SHIFT;
    else if (w_close) w_mode_nxt = IDLE;
  end

  // Data buffers carry no reset; their contents are qualified by r_pend_v.
  always_ff @(posedge clk) begin
    if (w_shift_mode && w_clk_rise && r_bit_cnt < CNT_FULL)
      r_stage[r_bit_cnt[IDX_W-1:0]] <= w_dat_lvl;
    if (w_good)        r_pend <= r_stage;
    else if (w_preset) r_pend <= w_rom;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_ret     <= IDLE;
      r_bit_cnt <= '0;
      r_pend_v  <= 1'b0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_offer   <= '0;
    end else begin
      if (w_open)
        r_bit_cnt <= '0;
      else if (w_shift_mode && w_clk_rise && r_bit_cnt != CNT_SAT)
        r_bit_cnt <= r_bit_cnt + 7'd1;

      // A write in the same cycle as a take keeps the new pattern pending.
      if (w_take) begin
        r_offer  <= r_pend;
        r_pend_v <= 1'b0;
      end
      if (w_good || w_preset) r_pend_v <= 1'b1;

      if (w_good)       r_err <= 1'b0;
      else if (w_close) r_err <= 1'b1;

      if (r_state == OFFER) begin
        if (r_valid && seed_ready) begin
          r_valid <= 1'b0;
          r_state <= w_mode_nxt;
        end else begin
          r_ret <= w_mode_nxt;
        end
      end else if (w_take) begin
        r_valid <= 1'b1;
        r_state <= OFFER;
        r_ret   <= w_mode_nxt;
      end else begin
        r_state <= w_mode_nxt;
      end
    end
  end

  assign seed_valid = r_valid;
  assign seed_cells = r_offer;
  assign xfer_err   = r_err;
  assign busy       = w_shift_mode || r_pend_v;

endmodule

// File: tb/tb_board_seed_loader.sv
module tb_board_seed_loader;

  localparam logic [63:0] P_UW      = 64'h50A8_8888_0609_0909;
  localparam logic [63:0] P_GLIDER  = 64'h0000_0000_0007_0402;
  localparam logic [63:0] P_BLINKER = 64'h0000_0000_0038_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ser_clk = 1'b0, ser_data = 1'b0, ser_latch = 1'b0;
  logic [1:0]  preset_sel = 2'd0;
  logic        preset_go = 1'b0, frame_tick = 1'b0, seed_ready = 1'b0;
  logic        seed_valid, busy, xfer_err;
  logic [63:0] seed_cells;

  board_seed_loader dut (
    .clk(clk), .reset(reset), .ser_clk(ser_clk), .ser_data(ser_data),
    .ser_latch(ser_latch), .preset_sel(preset_sel), .preset_go(preset_go),
    .frame_tick(frame_tick), .seed_ready(seed_ready), .seed_valid(seed_valid),
    .seed_cells(seed_cells), .busy(busy), .xfer_err(xfer_err));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Abstract model: one pending slot, one offered slot, sticky error.
  logic        m_valid = 0, m_pend_v = 0, m_err = 0, m_unk = 0, m_unk_pend = 0;
  logic [63:0] m_pend = '0, m_cells = '0;
  logic        settle = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rom(input logic [1:0] s);
    case (s)
      2'd0:    return P_UW;
      2'd1:    return P_GLIDER;
      2'd2:    return P_BLINKER;
      default: return 64'h0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid = 0; m_pend_v = 0; m_err = 0; m_cells = '0; m_unk = 0;
    end else if (m_valid && seed_ready) begin
      m_valid = 0;
    end else if (!m_valid && frame_tick && m_pend_v) begin
      m_cells  = m_pend;
      m_unk    = m_unk_pend;
      m_valid  = 1;
      m_pend_v = 0;
    end
  end

  always @(negedge clk) begin
    chk("valid_track", {63'd0, seed_valid}, {63'd0, m_valid});
    if (!m_unk) chk("cells_track", seed_cells, m_cells);
    if (!settle) chk("err_track", {63'd0, xfer_err}, {63'd0, m_err});
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] pat, input int n);
    settle = 1;
    ser_latch = 1;
    cyc(6);
    for (int i = 0; i < n; i++) begin
      ser_data = pat[i];
      cyc(2);
      ser_clk = 1;
      cyc(5);
      ser_clk = 0;
      cyc(3);
    end
    ser_latch = 0;
    cyc(6);
    if (n == 64) begin
      m_pend = pat; m_pend_v = 1; m_err = 0; m_unk_pend = 0;
    end else begin
      m_err = 1;
    end
    settle = 0;
  endtask

  task automatic preset(input logic [1:0] s);
    preset_sel = s;
    preset_go = 1;
    cyc(6);
    preset_go = 0;
    cyc(6);
    m_pend = rom(s);
    m_pend_v = 1;
`ifdef SEED_LFSR_EN
    m_unk_pend = (s == 2'd3);
`else
    m_unk_pend = 0;
`endif
  endtask

  task automatic tick();
    frame_tick = 1;
    cyc(1);
    frame_tick = 0;
  endtask

  initial begin
    #900_000;
    bad++;
    $display("FAIL watchdog: time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    logic [63:0] a;
    cyc(3);
    chk("rst_valid", {63'd0, seed_valid}, 64'd0);
    chk("rst_cells", seed_cells, 64'd0);
    chk("rst_busy",  {63'd0, busy}, 64'd0);
    chk("rst_err",   {63'd0, xfer_err}, 64'd0);
    reset = 0;
    cyc(3);

    // Preset UW with a one-cycle handshake.
    preset(2'd0);
    chk("uw_busy", {63'd0, busy}, 64'd1);
    tick();
    chk("uw_valid", {63'd0, seed_valid}, 64'd1);
    chk("uw_cells", seed_cells, P_UW);
    chk("model_uw", m_cells, 64'h50A8_8888_0609_0909);
    chk("uw_idle_busy", {63'd0, busy}, 64'd0);
    seed_ready = 1;
    cyc(1);
    chk("uw_drop", {63'd0, seed_valid}, 64'd0);

    // Serial glider.
    send(P_GLIDER, 64);
    tick();
    chk("gl_valid", {63'd0, seed_valid}, 64'd1);
    chk("gl_cells", seed_cells, 64'h0000_0000_0007_0402);
    chk("gl_err", {63'd0, xfer_err}, 64'd0);
    cyc(2);

    // Short transfer, then recovery.
    send(P_BLINKER, 63);
    chk("short_err", {63'd0, xfer_err}, 64'd1);
    tick();
    chk("short_nooffer", {63'd0, seed_valid}, 64'd0);
    send(P_UW, 64);
    chk("good_clears_err", {63'd0, xfer_err}, 64'd0);
    tick();
    chk("good_cells", seed_cells, P_UW);
    cyc(2);

    // Preset button during SHIFT is ignored; empty window is an error.
    settle = 1;
    ser_latch = 1;
    cyc(6);
    chk("shift_busy", {63'd0, busy}, 64'd1);
    preset_sel = 2'd2;
    preset_go = 1;
    cyc(6);
    preset_go = 0;
    cyc(6);
    ser_latch = 0;
    cyc(6);
    m_err = 1;
    settle = 0;
    chk("empty_err", {63'd0, xfer_err}, 64'd1);
    tick();
    chk("ignored_go", {63'd0, seed_valid}, 64'd0);
    chk("ignored_busy", {63'd0, busy}, 64'd0);

    // Latest preset wins.
    preset(2'd1);
    preset(2'd2);
    tick();
    chk("latest_cells", seed_cells, 64'h0000_0000_0038_0000);
    chk("model_blinker", m_cells, P_BLINKER);
    cyc(2);
`ifndef SEED_LFSR_EN
    preset(2'd3);
    tick();
    chk("preset3_zero", seed_cells, 64'd0);
    cyc(2);
`endif

    // Back-pressure across three frames while blinker loads.
    seed_ready = 0;
    send(P_GLIDER, 64);
    tick();
    chk("bp_first", seed_cells, P_GLIDER);
    fork
      send(P_BLINKER, 64);
      begin
        repeat (3) begin cyc(150); tick(); end
      end
    join
    chk("bp_hold_valid", {63'd0, seed_valid}, 64'd1);
    chk("bp_hold_cells", seed_cells, P_GLIDER);
    seed_ready = 1;
    cyc(1);
    chk("bp_accept", {63'd0, seed_valid}, 64'd0);
    tick();
    chk("bp_next", seed_cells, 64'h0000_0000_0038_0000);
    cyc(2);

    // Reset mid-SHIFT.
    settle = 1;
    ser_latch = 1;
    cyc(10);
    reset = 1;
    #1;
    chk("rs_shift_cells", seed_cells, 64'd0);
    chk("rs_shift_busy", {63'd0, busy}, 64'd0);
    chk("rs_shift_err", {63'd0, xfer_err}, 64'd0);
    ser_latch = 0;
    cyc(3);
    reset = 0;
    settle = 0;
    cyc(4);

    // Reset mid-OFFER.
    seed_ready = 0;
    preset(2'd0);
    tick();
    chk("offer_up", {63'd0, seed_valid}, 64'd1);
    reset = 1;
    #1;
    chk("rs_offer_valid", {63'd0, seed_valid}, 64'd0);
    chk("rs_offer_cells", seed_cells, 64'd0);
    cyc(2);
    reset = 0;
    cyc(2);

`ifdef SEED_LFSR_EN
    seed_ready = 1;
    preset(2'd3);
    tick();
    chk("lfsr_nonzero", {63'd0, (seed_cells != 64'd0)}, 64'd1);
    a = seed_cells;
    cyc(2);
    preset(2'd3);
    tick();
    chk("lfsr_differs", {63'd0, (seed_cells != a)}, 64'd1);
    cyc(2);
`else
    a = '0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
